// File: rtl/regfile_wb_if.sv
// Bundles the write-back requester handshakes and the register file write port.
// slave  : the arbiter side (takes requests, drives readies and WE3/A3/WD3).
// master : the requester/register-file side (a testbench or the pipeline).
// Signals:
//   req0_valid/addr/data, req0_ready : requester 0 (ALU) handshake
//   req1_valid/addr/data, req1_ready : requester 1 (LSU) handshake
//   we_o, waddr_o, wdata_o           : registered register file write port
interface regfile_wb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              we_o;
    logic [ADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0] wdata_o;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output we_o, waddr_o, wdata_o
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  we_o, waddr_o, wdata_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Owns the single write port of the register file. After reset it clears
// x1..x(2**ADDR_W-1) to zero, then shares the port between two write-back
// requesters with a round-robin valid/ready arbiter. Port outputs are registered.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   wb_stall  : pipeline freeze, suppresses all grants while high
//   bus       : regfile_wb_if slave modport (requesters + write port)
//   init_done : clear pass finished, arbiter accepting requests
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_stall,
    regfile_wb_if.slave   bus,
    output logic          init_done
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clearCnt_q, clearCnt_d;
    logic              favourReq1_q, favourReq1_d;
    logic              initDone_q, initDone_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant0, grant1, canGrant;

    // Grants only in RUN, outside reset and stall. When both requesters are
    // valid the pointer picks the one that did not win last time.
    always_comb begin
        canGrant = (state_q == ST_RUN) && !rst && !wb_stall;
        grant0   = canGrant && bus.req0_valid && (!bus.req1_valid || !favourReq1_q);
        grant1   = canGrant && bus.req1_valid && (!bus.req0_valid ||  favourReq1_q);
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Next-state: the clear pass walks the counter up to the last register,
    // then the granted request is loaded into the output register. A grant to
    // x0 completes the handshake but leaves the port idle.
    always_comb begin
        state_d      = state_q;
        clearCnt_d   = clearCnt_q;
        favourReq1_d = favourReq1_q;
        initDone_d   = initDone_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        if (state_q == ST_CLEAR) begin
            we_d       = 1'b1;
            waddr_d    = clearCnt_q;
            wdata_d    = '0;
            clearCnt_d = clearCnt_q + 1'b1;
            if (clearCnt_q == LAST_ADDR) begin
                state_d    = ST_RUN;
                initDone_d = 1'b1;
            end
        end else begin
            initDone_d = 1'b1;
            if (grant0) begin
                favourReq1_d = 1'b1;
                if (bus.req0_addr != '0) begin
                    we_d    = 1'b1;
                    waddr_d = bus.req0_addr;
                    wdata_d = bus.req0_data;
                end
            end else if (grant1) begin
                favourReq1_d = 1'b0;
                if (bus.req1_addr != '0) begin
                    we_d    = 1'b1;
                    waddr_d = bus.req1_addr;
                    wdata_d = bus.req1_data;
                end
            end
        end
    end

    // State and output registers; reset restarts the clear pass from x1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR_EN ? ST_CLEAR : ST_RUN;
            clearCnt_q   <= {{(ADDR_W-1){1'b0}}, 1'b1};
            favourReq1_q <= 1'b0;
            initDone_q   <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            clearCnt_q   <= clearCnt_d;
            favourReq1_q <= favourReq1_d;
            initDone_q   <= initDone_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.we_o    = we_q;
    assign bus.waddr_o = waddr_q;
    assign bus.wdata_o = wdata_q;
    assign init_done   = initDone_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter. The stimulus process
// drives requesters, predicts readies and the next-cycle write port from a
// behavioural model, and queues the expectation; a monitor pops one entry per
// cycle and compares it against the port.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wbStall = 1'b0;
    logic initDone;

    regfile_wb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_EN(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .wb_stall(wbStall),
        .bus(bus),
        .init_done(initDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          init;
        bit            chkAddr;
    } expT;

    expT expQ[$];
    int compared = 0;
    int mismatched = 0;

    // Behavioural model state
    bit            running = 1'b0;
    int            clearNext = 1;
    int            lastWinner = 1;
    logic [AW-1:0] holdAddr = '0;
    logic [DW-1:0] holdData = '0;
    bit            holdKnown = 1'b1;

    // Requester state: a pending request is held until it sees ready
    bit            pend [2];
    logic [AW-1:0] pAddr [2];
    logic [DW-1:0] pData [2];

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input expT e);
        checkVal("we_o", 64'(bus.we_o), 64'(e.we));
        checkVal("init_done", 64'(initDone), 64'(e.init));
        if (e.chkAddr) begin
            checkVal("waddr_o", 64'(bus.waddr_o), 64'(e.addr));
            checkVal("wdata_o", 64'(bus.wdata_o), 64'(e.data));
        end
    endtask

    // Monitor: one expectation per cycle, queued during the previous cycle
    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    task automatic newRequests(input int pct);
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < pct) begin
                pend[i]  = 1'b1;
                pAddr[i] = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
                pData[i] = $urandom;
            end
        end
    endtask

    task automatic setReq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i]  = 1'b1;
        pAddr[i] = a;
        pData[i] = d;
    endtask

    task automatic applyStimulus(input bit r, input bit st);
        expT e;
        int  win;
        @(negedge clk);
        rst            = r;
        wbStall        = st;
        bus.req0_valid = pend[0];
        bus.req0_addr  = pend[0] ? pAddr[0] : AW'($urandom);
        bus.req0_data  = pend[0] ? pData[0] : $urandom;
        bus.req1_valid = pend[1];
        bus.req1_addr  = pend[1] ? pAddr[1] : AW'($urandom);
        bus.req1_data  = pend[1] ? pData[1] : $urandom;
        #1;
        win = -1;
        if (!r && running && !st) begin
            if (pend[0] && pend[1]) win = 1 - lastWinner;
            else if (pend[0])       win = 0;
            else if (pend[1])       win = 1;
        end
        checkVal("req0_ready", 64'(bus.req0_ready), 64'(win == 0));
        checkVal("req1_ready", 64'(bus.req1_ready), 64'(win == 1));
        if (r) begin
            e = '{we: 1'b0, addr: '0, data: '0, init: 1'b0, chkAddr: 1'b1};
            running    = 1'b0;
            clearNext  = 1;
            lastWinner = 1;
            holdAddr   = '0;
            holdData   = '0;
            holdKnown  = 1'b1;
            pend[0]    = 1'b0;
            pend[1]    = 1'b0;
        end else if (!running) begin
            e = '{we: 1'b1, addr: AW'(clearNext), data: '0, init: (clearNext == NREG - 1), chkAddr: 1'b1};
            holdAddr  = AW'(clearNext);
            holdData  = '0;
            holdKnown = 1'b1;
            if (clearNext == NREG - 1) running = 1'b1;
            clearNext++;
        end else if (win >= 0 && pAddr[win] != '0) begin
            e = '{we: 1'b1, addr: pAddr[win], data: pData[win], init: 1'b1, chkAddr: 1'b1};
            holdAddr  = pAddr[win];
            holdData  = pData[win];
            holdKnown = 1'b1;
        end else begin
            e = '{we: 1'b0, addr: holdAddr, data: holdData, init: 1'b1, chkAddr: holdKnown};
            if (win >= 0) holdKnown = 1'b0;
        end
        if (win >= 0) begin
            lastWinner = win;
            pend[win]  = 1'b0;
        end
        expQ.push_back(e);
    endtask

    initial begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Two reset cycles, then a clear pass with requesters knocking
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (NREG - 1) begin
            newRequests(40);
            applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        end
        repeat (3) applyStimulus(1'b0, 1'b0);

        // Lone req0 write
        setReq(0, 5'd5, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // From reset: both valid continuously, grants must alternate
        applyStimulus(1'b1, 1'b0);
        repeat (NREG - 1) applyStimulus(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (!pend[0]) setReq(0, 5'd3, $urandom);
            if (!pend[1]) setReq(1, 5'd4, $urandom);
            applyStimulus(1'b0, 1'b0);
        end
        repeat (2) applyStimulus(1'b0, 1'b0);

        // Write to x0 is accepted but dropped
        setReq(1, 5'd0, 32'h1234);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // Stall with both valid, then the saved pointer decides
        setReq(0, 5'd9, $urandom);
        setReq(1, 5'd10, $urandom);
        repeat (3) applyStimulus(1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0);

        // Reset while req0 would be granted, clear restarts at x1
        setReq(0, 5'd7, $urandom);
        applyStimulus(1'b1, 1'b0);
        repeat (NREG + 2) applyStimulus(1'b0, 1'b0);

        // Randomized traffic with stalls and occasional resets
        repeat (600) begin
            newRequests(60);
            applyStimulus(1'($urandom_range(0, 249) == 0), 1'($urandom_range(0, 4) == 0));
        end

        @(negedge clk);
        #2;
        checkVal("queueDrained", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
